// File: rtl/nonce_sweep_scheduler.sv
// rtl/nonce_sweep_scheduler.sv - batch nonce sweep controller: launches the hash core,
// scans per-nonce H0 results, tracks best hash and stops on hit, limit, timeout or abort.
module nonce_sweep_scheduler #(
  parameter int NONCES_PER_BATCH = 16,
  parameter int MAX_BATCHES      = 256,
  parameter int TIMEOUT          = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] target,
  input  logic [15:0] output_addr,
  output logic        core_start,
  output logic [31:0] core_nonce_base,
  input  logic        core_done,
  output logic        mem_sel,
  output logic [15:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        timeout_err,
  output logic [31:0] found_nonce,
  output logic [31:0] found_hash,
  output logic [31:0] best_nonce,
  output logic [31:0] best_hash,
  output logic [15:0] batches_done
);

  localparam int IDX_W = $clog2(NONCES_PER_BATCH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_CORE, SCAN, EVAL, FINISH} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q, cmp_idx_q;
  logic              vld_q;
  logic [WD_W-1:0]   wd_q;
  logic [31:0]       target_q, base_q;
  logic              core_start_q, mem_sel_q, busy_q, done_q, found_q, timeout_q;
  logic [15:0]       rd_addr_q, batches_q;
  logic [31:0]       found_nonce_q, found_hash_q, best_nonce_q, best_hash_q;

  logic [31:0]       nonce_d;
  logic              better_d, hit_d, last_batch_d;
  logic [32:0]       base_sum_d;

  always_comb begin
    nonce_d      = base_q + 32'(cmp_idx_q);
    better_d     = rd_data < best_hash_q;
    hit_d        = (rd_data < target_q) && !found_q;
    base_sum_d   = {1'b0, base_q} + 33'(NONCES_PER_BATCH);
    last_batch_d = found_q || (batches_q + 16'd1 == 16'(MAX_BATCHES)) || base_sum_d[32];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cmp_idx_q     <= '0;
      vld_q         <= 1'b0;
      wd_q          <= '0;
      target_q      <= '0;
      base_q        <= '0;
      core_start_q  <= 1'b0;
      mem_sel_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      timeout_q     <= 1'b0;
      rd_addr_q     <= '0;
      batches_q     <= '0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      best_nonce_q  <= '0;
      best_hash_q   <= 32'hFFFF_FFFF;
    end else begin
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort && state_q != IDLE) begin
        // Abort drops everything without a done pulse; results stay as they are.
        state_q   <= IDLE;
        mem_sel_q <= 1'b0;
        busy_q    <= 1'b0;
        vld_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            target_q      <= target;
            base_q        <= '0;
            batches_q     <= '0;
            found_q       <= 1'b0;
            timeout_q     <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            best_nonce_q  <= '0;
            best_hash_q   <= 32'hFFFF_FFFF;
            wd_q          <= '0;
            core_start_q  <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= LAUNCH;
          end
          LAUNCH: begin
            wd_q    <= wd_q + 1'b1;
            state_q <= WAIT_CORE;
          end
          WAIT_CORE: begin
            // The watchdog counts from the launch cycle, so expiry lands TIMEOUT cycles after it.
            if (core_done) begin
              mem_sel_q <= 1'b1;
              idx_q     <= '0;
              vld_q     <= 1'b0;
              rd_addr_q <= output_addr;
              state_q   <= SCAN;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= FINISH;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          SCAN: begin
            vld_q     <= idx_q != IDX_W'(NONCES_PER_BATCH);
            cmp_idx_q <= idx_q;
            idx_q     <= idx_q + 1'b1;
            rd_addr_q <= rd_addr_q + 16'd1;
            if (vld_q) begin
              if (better_d) begin
                best_hash_q  <= rd_data;
                best_nonce_q <= nonce_d;
              end
              if (hit_d) begin
                found_q       <= 1'b1;
                found_nonce_q <= nonce_d;
                found_hash_q  <= rd_data;
              end
            end
            if (idx_q == IDX_W'(NONCES_PER_BATCH)) state_q <= EVAL;
          end
          EVAL: begin
            batches_q <= batches_q + 16'd1;
            mem_sel_q <= 1'b0;
            if (last_batch_d) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              base_q       <= base_sum_d[31:0];
              wd_q         <= '0;
              core_start_q <= 1'b1;
              state_q      <= LAUNCH;
            end
          end
          FINISH: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign core_start      = core_start_q;
  assign core_nonce_base = base_q;
  assign mem_sel         = mem_sel_q;
  assign rd_addr         = rd_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign found           = found_q;
  assign timeout_err     = timeout_q;
  assign found_nonce     = found_nonce_q;
  assign found_hash      = found_hash_q;
  assign best_nonce      = best_nonce_q;
  assign best_hash       = best_hash_q;
  assign batches_done    = batches_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// tb/tb_nonce_sweep_scheduler.sv - directed bench for nonce_sweep_scheduler with a
// behavioural hash core and 1-cycle-latency result memory.
module tb_nonce_sweep_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] target = '0;
  logic [15:0] output_addr = '0;
  logic        core_start, mem_sel, busy, done, found, timeout_err;
  logic [31:0] core_nonce_base, found_nonce, found_hash, best_nonce, best_hash, rd_data = '0;
  logic [15:0] rd_addr, batches_done;
  logic        core_done_m = 1'b0, stray_done = 1'b0;
  logic        core_done_w;

  assign core_done_w = core_done_m | stray_done;

  nonce_sweep_scheduler #(.NONCES_PER_BATCH(16), .MAX_BATCHES(3), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .target(target),
    .output_addr(output_addr), .core_start(core_start), .core_nonce_base(core_nonce_base),
    .core_done(core_done_w), .mem_sel(mem_sel), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .found(found), .timeout_err(timeout_err),
    .found_nonce(found_nonce), .found_hash(found_hash), .best_nonce(best_nonce),
    .best_hash(best_hash), .batches_done(batches_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_fail = 0;
  int          mode = 0;
  logic        core_en = 1'b1, stray_en = 1'b0;
  logic [31:0] core_base = '0;
  int          cyc = 0, n_starts = 0, n_done = 0, start_cyc = 0, done_cyc = 0, naddr = 0;
  logic        msel_seen = 1'b0;
  logic [31:0] bases [8];
  logic [15:0] addrs [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_hash(input logic [31:0] n);
    if (mode == 0) return 32'h1000_0000 + n;
    if (n == 32'd21) return 32'h0000_0F00;
    if (n == 32'd25) return 32'h0000_0E00;
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_starts = 0; n_done = 0; naddr = 0; msel_seen = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) tick();
    check(tag, 32'(n_done != 0), 32'd1);
  endtask

  // Monitor: records launches, done pulses, memory ownership and scan addresses.
  initial forever begin
    @(negedge clk);
    if (core_start) begin
      if (n_starts < 8) bases[n_starts] = core_nonce_base;
      n_starts++;
      start_cyc = cyc;
    end
    stray_done = core_start && stray_en;
    if (done) begin n_done++; done_cyc = cyc; end
    if (mem_sel) begin
      msel_seen = 1'b1;
      if (naddr < 16) begin addrs[naddr] = rd_addr; naddr++; end
    end
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (core_start && core_en) begin
      core_base = core_nonce_base;
      repeat (4) @(negedge clk);
      core_done_m = 1'b1;
      @(negedge clk);
      core_done_m = 1'b0;
    end
  end

  initial forever begin
    logic [15:0] a;
    @(negedge clk);
    a = rd_addr - output_addr;
    @(posedge clk);
    #1 rd_data = model_hash(core_base + 32'(a));
  end

  initial begin
    repeat (3) tick();
    check("rst_best_hash", best_hash, 32'hFFFF_FFFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_batches", {16'd0, batches_done}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_outputs", {27'd0, core_start, mem_sel, done, found, timeout_err}, 32'd0);

    // Exhaust MAX_BATCHES with no hit.
    mode = 0; target = 32'h1; output_addr = 16'h0100; clear_mon();
    pulse_start();
    wait_done("t1_done", 2000);
    check("t1_starts", n_starts, 3);
    check("t1_base0", bases[0], 32'd0);
    check("t1_base1", bases[1], 32'd16);
    check("t1_base2", bases[2], 32'd32);
    check("t1_found", {31'd0, found}, 32'd0);
    check("t1_best_hash", best_hash, 32'h1000_0000);
    check("t1_best_nonce", best_nonce, 32'd0);
    check("t1_batches", {16'd0, batches_done}, 32'd3);
    tick();
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // First hit wins, best continues to improve within the batch.
    mode = 1; target = 32'h0000_1000; clear_mon();
    pulse_start();
    wait_done("t2_done", 2000);
    check("t2_starts", n_starts, 2);
    check("t2_found", {31'd0, found}, 32'd1);
    check("t2_found_nonce", found_nonce, 32'd21);
    check("t2_found_hash", found_hash, 32'h0000_0F00);
    check("t2_best_nonce", best_nonce, 32'd25);
    check("t2_best_hash", best_hash, 32'h0000_0E00);
    check("t2_batches", {16'd0, batches_done}, 32'd2);
    tick();

    // Core never finishes.
    core_en = 1'b0; clear_mon();
    pulse_start();
    wait_done("t3_done", 5000);
    check("t3_timeout_err", {31'd0, timeout_err}, 32'd1);
    check("t3_latency", done_cyc - start_cyc, 32'd4096);
    check("t3_mem_sel", {31'd0, msel_seen}, 32'd0);
    check("t3_batches", {16'd0, batches_done}, 32'd0);
    core_en = 1'b1;
    repeat (2) tick();

    // Abort in the middle of the first scan, then a clean restart.
    mode = 0; target = 32'h1; clear_mon();
    pulse_start();
    for (int k = 0; k < 200 && !mem_sel; k++) tick();
    check("t4_in_scan", {31'd0, mem_sel}, 32'd1);
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_mem_sel", {31'd0, mem_sel}, 32'd0);
    repeat (5) tick();
    check("t4_no_done", n_done, 0);
    check("t4_retained_best", best_hash, 32'h1000_0000);
    check("t4_retained_batches", {16'd0, batches_done}, 32'd0);
    clear_mon();
    pulse_start();
    wait_done("t4_re_done", 2000);
    check("t4_re_starts", n_starts, 3);
    check("t4_re_best", best_hash, 32'h1000_0000);
    check("t4_re_batches", {16'd0, batches_done}, 32'd3);
    tick();

    // start held high, stray core_done during LAUNCH, wrapping scan addresses, target 0.
    target = 32'h0; output_addr = 16'hFFF8; stray_en = 1'b1; clear_mon();
    start = 1'b1;
    for (int k = 0; k < 2000 && n_done == 0; k++) tick();
    start = 1'b0;
    check("t5_done", 32'(n_done != 0), 32'd1);
    repeat (5) tick();
    stray_en = 1'b0;
    check("t5_starts", n_starts, 3);
    check("t5_one_done", n_done, 1);
    check("t5_found", {31'd0, found}, 32'd0);
    check("t5_batches", {16'd0, batches_done}, 32'd3);
    check("t5_naddr", naddr, 16);
    for (int k = 0; k < 16; k++) check($sformatf("t5_addr%0d", k), {16'd0, addrs[k]}, {16'd0, 16'hFFF8 + 16'(k)});

    // Asynchronous reset while waiting on the second batch.
    output_addr = 16'h0100; clear_mon();
    pulse_start();
    for (int k = 0; k < 200 && n_starts < 2; k++) tick();
    check("t6_second_launch", n_starts, 2);
    repeat (2) tick();
    check("t6_pre_base", core_nonce_base, 32'd16);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_best_hash", best_hash, 32'hFFFF_FFFF);
    check("t6_base", core_nonce_base, 32'd0);
    check("t6_batches", {16'd0, batches_done}, 32'd0);
    check("t6_mem_sel", {31'd0, mem_sel}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nonce_sweep_scheduler.md
Name: nonce_sweep_scheduler

Overview:
Controller that sweeps nonce space by repeatedly launching the bitcoin hash core on batches of NONCES_PER_BATCH nonces. After each batch it takes ownership of the shared memory port, reads the per-nonce final H0 words, and compares them against a difficulty target. It tracks the best (minimum) hash and stops on the first hit, batch exhaustion, core timeout, or abort.

Parameters:
NONCES_PER_BATCH, 16, nonces per core run; result words read per batch
MAX_BATCHES, 256, batch limit per sweep (1..65535)
TIMEOUT, 4096, max cycles waited for core_done per batch

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  terminate sweep; any state
target  in  32  hit when hash < target (unsigned)
output_addr  in  16  base address of core result words
core_start  out  1  one-cycle launch pulse to core
core_nonce_base  out  32  first nonce of current batch
core_done  in  1  core completion pulse
mem_sel  out  1  0 = core owns memory, 1 = scheduler owns memory
rd_addr  out  16  scheduler read address
rd_data  in  32  read data, 1-cycle latency after rd_addr
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at sweep end
found  out  1  hit recorded
timeout_err  out  1  core failed to finish a batch
found_nonce  out  32  nonce of first hit
found_hash  out  32  hash of first hit
best_nonce  out  32  nonce of minimum hash seen
best_hash  out  32  minimum hash seen this sweep
batches_done  out  16  completed batches this sweep

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state IDLE; every output 0, except best_hash = 0xFFFFFFFF.
- States: IDLE, LAUNCH, WAIT_CORE, SCAN, EVAL, FINISH.
- IDLE, start=1: latch target; clear base, batches_done, found, timeout_err, found_*, best_nonce; set best_hash = 0xFFFFFFFF; go to LAUNCH. start is ignored in every other state.
- LAUNCH: core_start = 1 for exactly this cycle; core_nonce_base = base (held stable until the next LAUNCH); mem_sel = 0; clear the watchdog; go to WAIT_CORE.
- WAIT_CORE: core_done is sampled only in this state.
  - core_done = 1: set mem_sel = 1, clear idx, go to SCAN.
  - Watchdog reaches TIMEOUT-1 without core_done: set timeout_err, go to FINISH.
- SCAN, idx 0..NONCES_PER_BATCH-1: rd_addr = output_addr + idx, one read per cycle. Address adds wrap mod 2^16.
- SCAN compare stage:
  - A data-valid flag is delayed 1 cycle; the compare for index j happens the cycle after its address is issued.
  - Hash = rd_data; nonce = base + j (mod 2^32).
  - hash < best_hash (strict): update best_hash and best_nonce. Ties keep the earlier nonce.
  - hash < target and found = 0: set found and capture found_nonce / found_hash. Only the first hit in scan order is captured.
  - SCAN lasts NONCES_PER_BATCH+1 cycles; after the final compare, go to EVAL.
- EVAL: batches_done += 1. Go to FINISH if found, or batches_done reaches MAX_BATCHES, or base + NONCES_PER_BATCH wraps past 2^32. Otherwise base += NONCES_PER_BATCH and go to LAUNCH.
- FINISH: done = 1 for one cycle, mem_sel = 0, go to IDLE. Results hold until the next start.
- abort = 1 in any non-IDLE state: next cycle state = IDLE, mem_sel = 0, core_start = 0, no done pulse, results retain their current values. abort takes priority over core_done and over watchdog expiry in the same cycle.
- target = 0: no hit is possible; the sweep runs to MAX_BATCHES.
- mem_sel is 1 only in SCAN and EVAL.

Test Plan:
- Model core returns hash = 0x10000000 + nonce; target = 0x00000001, MAX_BATCHES = 3 -> 3 core_start pulses with bases 0, 16, 32; found = 0; best_hash = 0x10000000, best_nonce = 0; batches_done = 3; done after batch 3.
- Core returns 0xFFFFFFFF except nonce 21 = 0x00000F00 and nonce 25 = 0x00000E00; target = 0x00001000 -> stop after batch 2; found_nonce = 21, found_hash = 0x00000F00; best_nonce = 25; batches_done = 2.
- Core never asserts core_done, TIMEOUT = 4096 -> timeout_err = 1 and done pulse 4096 cycles after LAUNCH; mem_sel = 0 throughout.
- abort asserted mid-SCAN (idx = 7) -> IDLE next cycle, mem_sel = 0, no done pulse; restart with start behaves identically to a fresh sweep.
- start held high for the whole sweep, plus core_done pulsed during LAUNCH -> only one sweep runs; the stray core_done is ignored; rd_addr sequence is output_addr .. output_addr+15.
- reset asserted in WAIT_CORE -> all outputs go to their reset values immediately (asynchronously), best_hash = 0xFFFFFFFF.
